// File: rtl/feature_pkg.sv
// Shared constants and state encoding for the feature loader and the
// downstream classifier, which is sized from the same defaults.
package feature_pkg;

  localparam int FEAT_W_DEF   = 32;
  localparam int NUM_FEAT_DEF = 5;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DISCARD = 2'd2
  } loader_state_t;

  // Slot index width; a one-feature frame still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_frame_loader_if.sv
// Stream-in / vector-out bus of the feature frame loader.
// slave: the loader's view; master: the producer/consumer side.
interface feature_frame_loader_if #(
  parameter int NUM_FEAT = feature_pkg::NUM_FEAT_DEF,
  parameter int FEAT_W   = feature_pkg::FEAT_W_DEF
);

  logic                       s_valid;
  logic [FEAT_W-1:0]          s_data;
  logic                       s_last;
  logic                       s_ready;
  logic                       m_valid;
  logic                       m_ready;
  logic [NUM_FEAT*FEAT_W-1:0] feat_vec;
  logic                       frame_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, feat_vec, frame_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, feat_vec, frame_err
  );

endinterface

// File: rtl/feature_frame_loader_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on inc until the counter reaches its maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/feature_frame_loader.sv
// Feature frame loader: assembles NUM_FEAT serial feature words into one
// parallel vector for the classifier and drops malformed frames.
// Optional macro FRAME_ERR_CNT_EN adds a saturating dropped-frame counter
// (err_count port, ERR_CNT_W bits).
module feature_frame_loader
  import feature_pkg::*;
#(
  parameter int NUM_FEAT = NUM_FEAT_DEF,
  parameter int FEAT_W   = FEAT_W_DEF
`ifdef FRAME_ERR_CNT_EN
  , parameter int ERR_CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef FRAME_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  feature_frame_loader_if.slave bus
);

  localparam int               IDX_W    = idx_w(NUM_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  loader_state_t                   state, state_nxt;
  logic [IDX_W-1:0]                idx, idx_nxt;
  logic                            acc, out_free;
  logic                            wr, load, err_set;
  logic [NUM_FEAT-1:0][FEAT_W-1:0] collect, frame_nxt;

  // Stalling input only while a finished frame waits for the output slot.
  assign bus.s_ready = (state != FULL);
  assign acc         = bus.s_valid && bus.s_ready;
  assign out_free    = !bus.m_valid || bus.m_ready;

  // State and slot index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= COLLECT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: frame length checks, load and error decisions.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr        = 1'b0;
    load      = 1'b0;
    err_set   = 1'b0;
    case (state)
      COLLECT: begin
        if (acc) begin
          wr = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            if (bus.s_last) begin
              if (out_free) load = 1'b1;
              else          state_nxt = FULL;
            end else begin
              // Too long: flag now, swallow the rest up to s_last.
              err_set   = 1'b1;
              state_nxt = DISCARD;
            end
          end else if (bus.s_last) begin
            err_set = 1'b1;
            idx_nxt = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      FULL: begin
        if (out_free) begin
          load      = 1'b1;
          state_nxt = COLLECT;
        end
      end
      DISCARD: begin
        if (acc && bus.s_last) begin
          state_nxt = COLLECT;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = COLLECT;
        idx_nxt   = '0;
      end
    endcase
  end

  // Per-slot collect registers; frame_nxt folds in the beat being written so
  // the completing beat can go straight to the output in the same cycle.
  for (genvar i = 0; i < NUM_FEAT; i++) begin : g_slot
    logic hit;
    assign hit          = wr && (idx == IDX_W'(i));
    assign frame_nxt[i] = hit ? bus.s_data : collect[i];

    // Capture the feature word addressed by idx.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)     collect[i] <= '0;
      else if (hit) collect[i] <= bus.s_data;
    end
  end

  // Output vector, valid flag and the one-cycle error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.m_valid   <= 1'b0;
      bus.feat_vec  <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= err_set;
      if (load) begin
        bus.feat_vec <= frame_nxt;
        bus.m_valid  <= 1'b1;
      end else if (bus.m_ready) begin
        bus.m_valid  <= 1'b0;
      end
    end
  end

`ifdef FRAME_ERR_CNT_EN
  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_set),
    .count (err_count)
  );
`endif

endmodule
